interleave_ctrl_s_axi: RTL and testbench



---
 rtl/interleave_ctrl_s_axi.sv | 275 +++++++++++++++++++++++++++
 tb/tb_interleave_ctrl_s_axi.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interleave_ctrl_s_axi.sv
// interleave_ctrl_s_axi
//   AXI4-Lite control slave for the interleave kernel. Host software programs
//   insize / in_ptr / out_ptr and sets ap_start. Kernel ap_done / ap_idle
//   come back as host-readable status, and a level interrupt is raised on
//   completion.
//
//   Optional build macro: INTERLEAVE_CTRL_AUTO_RESTART_EN
//     When defined, CTRL bit7 (auto_restart) is R/W and keeps ap_start
//     asserted across ap_done. When undefined, bit7 reads 0 and ignores writes.
//
// Ports
//   ap_clk, areset            clock, asynchronous active-high reset
//   s_axi_control_aw*         write address channel (awvalid/awready/awaddr)
//   s_axi_control_w*          write data channel (wvalid/wready/wdata/wstrb)
//   s_axi_control_b*          write response channel (bvalid/bready/bresp)
//   s_axi_control_ar*         read address channel (arvalid/arready/araddr)
//   s_axi_control_r*          read data channel (rvalid/rready/rdata/rresp)
//   interrupt                 level interrupt to host
//   ap_start                  level start to kernel
//   ap_done, ap_idle          kernel completion pulse / idle level
//   insize, in_ptr, out_ptr   kernel argument registers
//
// Register map (byte offsets)
//   0x00 CTRL  0 ap_start, 1 ap_done (COR), 2 ap_idle, 3 ap_ready (COR),
//              7 auto_restart
//   0x04 GIE   0x08 IER[1:0]   0x0C ISR[1:0] (toggle on write 1)
//   0x10 insize  0x14/0x18 in_ptr lo/hi  0x1C/0x20 out_ptr lo/hi

module interleave_ctrl_s_axi #(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  logic                            s_axi_control_awvalid,
  output logic                            s_axi_control_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_awaddr,
  input  logic                            s_axi_control_wvalid,
  output logic                            s_axi_control_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_control_wstrb,
  output logic                            s_axi_control_bvalid,
  input  logic                            s_axi_control_bready,
  output logic [1:0]                      s_axi_control_bresp,
  input  logic                            s_axi_control_arvalid,
  output logic                            s_axi_control_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_araddr,
  output logic                            s_axi_control_rvalid,
  input  logic                            s_axi_control_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_rdata,
  output logic [1:0]                      s_axi_control_rresp,
  output logic                            interrupt,
  output logic                            ap_start,
  input  logic                            ap_done,
  input  logic                            ap_idle,
  output logic [31:0]                     insize,
  output logic [63:0]                     in_ptr,
  output logic [63:0]                     out_ptr
);

  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_CTRL    = C_S_AXI_ADDR_WIDTH'(6'h00);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_GIE     = C_S_AXI_ADDR_WIDTH'(6'h04);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_IER     = C_S_AXI_ADDR_WIDTH'(6'h08);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_ISR     = C_S_AXI_ADDR_WIDTH'(6'h0C);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_INSIZE  = C_S_AXI_ADDR_WIDTH'(6'h10);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_INP_LO  = C_S_AXI_ADDR_WIDTH'(6'h14);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_INP_HI  = C_S_AXI_ADDR_WIDTH'(6'h18);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_OUTP_LO = C_S_AXI_ADDR_WIDTH'(6'h1C);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_OUTP_HI = C_S_AXI_ADDR_WIDTH'(6'h20);

  typedef enum logic [1:0] {WRRESET, WRIDLE, WRDATA, WRRESP} wr_state_t;
  typedef enum logic [1:0] {RDRESET, RDIDLE, RDDATA} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [C_S_AXI_ADDR_WIDTH-1:0] waddr;
  logic [31:0]                   wmask;
  logic                          aw_hs, w_hs, ar_hs;

  logic        int_start, int_done, int_ready, int_gie, auto_restart;
  logic [1:0]  int_ier, int_isr;
  logic [31:0] int_insize, int_inp_lo, int_inp_hi, int_outp_lo, int_outp_hi;
  logic [31:0] rd_mux;

  logic wr_ctrl, wr_gie, wr_ier, wr_isr;
  logic rd_ctrl;

  // ---------------- write channel FSM ----------------
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) wr_state <= WRRESET;
    else        wr_state <= wr_next;
  end

  always_comb begin
    wr_next               = wr_state;
    s_axi_control_awready = 1'b0;
    s_axi_control_wready  = 1'b0;
    s_axi_control_bvalid  = 1'b0;
    unique case (wr_state)
      WRRESET: wr_next = WRIDLE;
      WRIDLE: begin
        s_axi_control_awready = 1'b1;
        if (s_axi_control_awvalid) wr_next = WRDATA;
      end
      WRDATA: begin
        s_axi_control_wready = 1'b1;
        if (s_axi_control_wvalid) wr_next = WRRESP;
      end
      WRRESP: begin
        s_axi_control_bvalid = 1'b1;
        if (s_axi_control_bready) wr_next = WRIDLE;
      end
      default: wr_next = WRRESET;
    endcase
  end

  assign s_axi_control_bresp = '0;
  assign aw_hs = s_axi_control_awvalid & s_axi_control_awready;
  assign w_hs  = s_axi_control_wvalid  & s_axi_control_wready;

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset)     waddr <= '0;
    else if (aw_hs) waddr <= s_axi_control_awaddr;
  end

  assign wmask = {{8{s_axi_control_wstrb[3]}}, {8{s_axi_control_wstrb[2]}},
                  {8{s_axi_control_wstrb[1]}}, {8{s_axi_control_wstrb[0]}}};

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] data,
                                        input logic [31:0] mask);
    return (old & ~mask) | (data & mask);
  endfunction

  // Single-bit control registers live in byte 0, so only wstrb[0] gates them.
  assign wr_ctrl = w_hs && (waddr == ADDR_CTRL) && s_axi_control_wstrb[0];
  assign wr_gie  = w_hs && (waddr == ADDR_GIE)  && s_axi_control_wstrb[0];
  assign wr_ier  = w_hs && (waddr == ADDR_IER)  && s_axi_control_wstrb[0];
  assign wr_isr  = w_hs && (waddr == ADDR_ISR)  && s_axi_control_wstrb[0];

  // ---------------- read channel FSM ----------------
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) rd_state <= RDRESET;
    else        rd_state <= rd_next;
  end

  always_comb begin
    rd_next               = rd_state;
    s_axi_control_arready = 1'b0;
    s_axi_control_rvalid  = 1'b0;
    unique case (rd_state)
      RDRESET: rd_next = RDIDLE;
      RDIDLE: begin
        s_axi_control_arready = 1'b1;
        if (s_axi_control_arvalid) rd_next = RDDATA;
      end
      RDDATA: begin
        s_axi_control_rvalid = 1'b1;
        if (s_axi_control_rready) rd_next = RDIDLE;
      end
      default: rd_next = RDRESET;
    endcase
  end

  assign s_axi_control_rresp = '0;
  assign ar_hs   = s_axi_control_arvalid & s_axi_control_arready;
  assign rd_ctrl = ar_hs && (s_axi_control_araddr == ADDR_CTRL);

  always_comb begin
    rd_mux = '0;
    case (s_axi_control_araddr)
      ADDR_CTRL:    rd_mux = {24'b0, auto_restart, 3'b0, int_ready, ap_idle, int_done, int_start};
      ADDR_GIE:     rd_mux = {31'b0, int_gie};
      ADDR_IER:     rd_mux = {30'b0, int_ier};
      ADDR_ISR:     rd_mux = {30'b0, int_isr};
      ADDR_INSIZE:  rd_mux = int_insize;
      ADDR_INP_LO:  rd_mux = int_inp_lo;
      ADDR_INP_HI:  rd_mux = int_inp_hi;
      ADDR_OUTP_LO: rd_mux = int_outp_lo;
      ADDR_OUTP_HI: rd_mux = int_outp_hi;
      default:      rd_mux = '0;
    endcase
  end

  // rdata is captured once at the AR handshake and held until rready.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset)     s_axi_control_rdata <= '0;
    else if (ar_hs) s_axi_control_rdata <= rd_mux;
  end

  // ---------------- control / status ----------------
`ifdef INTERLEAVE_CTRL_AUTO_RESTART_EN
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset)       auto_restart <= 1'b0;
    else if (wr_ctrl) auto_restart <= s_axi_control_wdata[7];
  end
`else
  assign auto_restart = '0;
`endif

  // With auto_restart set, ap_done leaves ap_start high so the kernel re-runs.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset)                                int_start <= 1'b0;
    else if (wr_ctrl && s_axi_control_wdata[0]) int_start <= 1'b1;
    else if (ap_done && !auto_restart)         int_start <= 1'b0;
  end

  // A completion pulse coinciding with the clearing read keeps the bit set.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      int_done  <= 1'b0;
      int_ready <= 1'b0;
    end else if (ap_done) begin
      int_done  <= 1'b1;
      int_ready <= 1'b1;
    end else if (rd_ctrl) begin
      int_done  <= 1'b0;
      int_ready <= 1'b0;
    end
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      int_gie <= 1'b0;
      int_ier <= '0;
    end else begin
      if (wr_gie) int_gie <= s_axi_control_wdata[0];
      if (wr_ier) int_ier <= s_axi_control_wdata[1:0];
    end
  end

  // Hardware set takes priority over a same-cycle host toggle.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      int_isr <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (ap_done && int_ier[i])                 int_isr[i] <= 1'b1;
        else if (wr_isr && s_axi_control_wdata[i]) int_isr[i] <= ~int_isr[i];
      end
    end
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) interrupt <= 1'b0;
    else        interrupt <= int_gie & |(int_isr & int_ier);
  end

  // ---------------- kernel argument registers ----------------
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      int_insize  <= '0;
      int_inp_lo  <= '0;
      int_inp_hi  <= '0;
      int_outp_lo <= '0;
      int_outp_hi <= '0;
    end else if (w_hs) begin
      case (waddr)
        ADDR_INSIZE:  int_insize  <= merge(int_insize,  s_axi_control_wdata, wmask);
        ADDR_INP_LO:  int_inp_lo  <= merge(int_inp_lo,  s_axi_control_wdata, wmask);
        ADDR_INP_HI:  int_inp_hi  <= merge(int_inp_hi,  s_axi_control_wdata, wmask);
        ADDR_OUTP_LO: int_outp_lo <= merge(int_outp_lo, s_axi_control_wdata, wmask);
        ADDR_OUTP_HI: int_outp_hi <= merge(int_outp_hi, s_axi_control_wdata, wmask);
        default: ;
      endcase
    end
  end

  assign ap_start = int_start;
  assign insize   = int_insize;
  assign in_ptr   = {int_inp_hi, int_inp_lo};
  assign out_ptr  = {int_outp_hi, int_outp_lo};

endmodule

// File: tb/tb_interleave_ctrl_s_axi.sv
// tb_interleave_ctrl_s_axi
//   Directed self-checking bench for interleave_ctrl_s_axi: register map,
//   byte strobes, clear-on-read status, interrupt path, read back-pressure
//   and reset in the middle of a write.

module tb_interleave_ctrl_s_axi;

  logic        clk = 1'b0;
  logic        areset;
  logic        awvalid, awready;
  logic [5:0]  awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [5:0]  araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        interrupt, ap_start, ap_done, ap_idle;
  logic [31:0] insize;
  logic [63:0] in_ptr, out_ptr;

  int tests = 0;
  int fails = 0;

  interleave_ctrl_s_axi #(
    .C_S_AXI_ADDR_WIDTH(6),
    .C_S_AXI_DATA_WIDTH(32)
  ) dut (
    .ap_clk(clk), .areset(areset),
    .s_axi_control_awvalid(awvalid), .s_axi_control_awready(awready),
    .s_axi_control_awaddr(awaddr),
    .s_axi_control_wvalid(wvalid), .s_axi_control_wready(wready),
    .s_axi_control_wdata(wdata), .s_axi_control_wstrb(wstrb),
    .s_axi_control_bvalid(bvalid), .s_axi_control_bready(bready),
    .s_axi_control_bresp(bresp),
    .s_axi_control_arvalid(arvalid), .s_axi_control_arready(arready),
    .s_axi_control_araddr(araddr),
    .s_axi_control_rvalid(rvalid), .s_axi_control_rready(rready),
    .s_axi_control_rdata(rdata), .s_axi_control_rresp(rresp),
    .interrupt(interrupt), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle),
    .insize(insize), .in_ptr(in_ptr), .out_ptr(out_ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write; nb returns how many cycles bvalid was observed high.
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int nb);
    int n;
    awaddr = a; awvalid = 1'b1; n = 0;
    while (!awready && n < 20) begin tick(); n++; end
    if (!awready) check("aw_timeout", 0, 1);
    tick();
    awvalid = 1'b0;
    wdata = d; wstrb = s; wvalid = 1'b1; n = 0;
    while (!wready && n < 20) begin tick(); n++; end
    if (!wready) check("w_timeout", 0, 1);
    tick();
    wvalid = 1'b0;
    nb = 0; n = 0;
    while (bvalid && n < 20) begin
      check("bresp", {62'b0, bresp}, 0);
      nb++; tick(); n++;
    end
  endtask

  // Read; optionally pulses ap_done in the same cycle as the AR handshake.
  task automatic axi_read(input logic [5:0] a, input logic pulse, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    if (!arready) check("ar_timeout", 0, 1);
    if (pulse) ap_done = 1'b1;
    tick();
    arvalid = 1'b0; ap_done = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    if (!rvalid) check("r_timeout", 0, 1);
    d = rdata;
    if (rready) tick();
  endtask

  task automatic pulse_done();
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
  endtask

  initial begin
    int nb, n;
    logic [31:0] d;

    areset = 1'b1;
    awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = '0;
    bready = 1'b1; arvalid = 0; araddr = '0; rready = 1'b1;
    ap_done = 0; ap_idle = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_ap_start", ap_start, 0);
    check("rst_interrupt", interrupt, 0);
    check("rst_rdata", rdata, 0);
    areset = 1'b0;
    n = 0;
    while (!(awready && arready) && n < 5) begin tick(); n++; end
    check("rel_ready", awready & arready, 1);

    axi_read(6'h00, 0, d); check("ctrl_after_reset", d, 32'h4);
    for (int i = 0; i < 5; i++) begin
      logic [5:0] a;
      a = 6'(6'h10 + 4 * i);
      axi_read(a, 0, d); check("arg_after_reset", d, 0);
    end

    // Byte strobes and pointer assembly
    axi_write(6'h14, 32'hDEAD_BEEF, 4'b0011, nb); check("nb_inlo", nb, 1);
    axi_write(6'h18, 32'h1, 4'b1111, nb);         check("nb_inhi", nb, 1);
    check("in_ptr", in_ptr, 64'h0000_0001_0000_BEEF);
    axi_write(6'h10, 32'h1234_5678, 4'b1100, nb); check("nb_insize", nb, 1);
    check("insize_strb", insize, 32'h1234_0000);
    axi_write(6'h1C, 32'h89AB_CDEF, 4'b1111, nb);
    axi_write(6'h20, 32'h0123_4567, 4'b1111, nb);
    check("out_ptr", out_ptr, 64'h0123_4567_89AB_CDEF);
    axi_read(6'h20, 0, d); check("rd_outp_hi", d, 32'h0123_4567);
    axi_write(6'h24, 32'hFFFF_FFFF, 4'b1111, nb); check("nb_unmapped", nb, 1);
    axi_read(6'h24, 0, d); check("rd_unmapped", d, 0);

    // Start / done / interrupt
    axi_write(6'h04, 32'h1, 4'b1111, nb);
    axi_write(6'h08, 32'h1, 4'b1111, nb);
    axi_write(6'h00, 32'h1, 4'b1111, nb);
    check("ap_start_set", ap_start, 1);
    check("irq_idle", interrupt, 0);
    ap_idle = 1'b0;
    axi_read(6'h00, 0, d); check("ctrl_running", d, 32'h1);
    pulse_done();
    ap_idle = 1'b1;
    check("ap_start_clr", ap_start, 0);
    check("irq_latency", interrupt, 0);
    tick();
    check("irq_set", interrupt, 1);
    axi_read(6'h00, 0, d); check("ctrl_done", d, 32'hE);
    axi_read(6'h00, 0, d); check("ctrl_cleared", d, 32'h4);
    axi_read(6'h0C, 0, d); check("isr_set", d, 32'h1);
    axi_write(6'h0C, 32'h1, 4'b1111, nb);
    check("irq_cleared", interrupt, 0);
    axi_read(6'h0C, 0, d); check("isr_cleared", d, 0);

    // ap_done coincident with the clearing read
    axi_read(6'h00, 1, d); check("ctrl_race", d, 32'h4);
    axi_read(6'h00, 0, d); check("ctrl_after_race", d, 32'hE);

`ifdef INTERLEAVE_CTRL_AUTO_RESTART_EN
    axi_write(6'h00, 32'h81, 4'b1111, nb);
    pulse_done();
    check("auto_restart_hold", ap_start, 1);
    axi_read(6'h00, 0, d); check("ctrl_auto", d, 32'h8F);
    axi_write(6'h00, 32'h0, 4'b1111, nb);
    check("write0_no_effect", ap_start, 1);
    pulse_done();
    check("auto_restart_stop", ap_start, 0);
`else
    axi_write(6'h00, 32'h80, 4'b1111, nb);
    axi_read(6'h00, 0, d); check("bit7_ignored", d, 32'h4);
    check("bit7_no_start", ap_start, 0);
`endif

    // Read back-pressure
    rready = 1'b0;
    axi_read(6'h10, 0, d); check("stall_data", d, 32'h1234_0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_rvalid", rvalid, 1);
      check("stall_rdata", rdata, 32'h1234_0000);
      check("stall_arready", arready, 0);
    end
    rready = 1'b1;
    tick();
    check("stall_release", rvalid, 0);

    // Reset in the middle of a write
    axi_write(6'h00, 32'h1, 4'b1111, nb);
    check("pre_rst_start", ap_start, 1);
    awaddr = 6'h10; awvalid = 1'b1; n = 0;
    while (!awready && n < 20) begin tick(); n++; end
    tick();
    awvalid = 1'b0;
    check("in_wrdata", wready, 1);
    areset = 1'b1;
    #1;
    check("mid_awready", awready, 0);
    check("mid_wready", wready, 0);
    check("mid_bvalid", bvalid, 0);
    check("mid_arready", arready, 0);
    check("mid_rvalid", rvalid, 0);
    check("mid_start", ap_start, 0);
    check("mid_irq", interrupt, 0);
    check("mid_in_ptr", in_ptr, 0);
    check("mid_out_ptr", out_ptr, 0);
    check("mid_insize", insize, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_bvalid", bvalid, 0);
    end
    areset = 1'b0;
    check("rel_awready_low", awready, 0);
    n = 0;
    while (!(awready && arready) && n < 5) begin
      check("rel_no_bvalid", bvalid, 0);
      tick(); n++;
    end
    check("rel_ready2", awready & arready, 1);
    axi_write(6'h10, 32'hCAFE_F00D, 4'b1111, nb);
    check("post_rst_nb", nb, 1);
    check("post_rst_insize", insize, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
